// File: rtl/divider_48_16_if.sv
// Operand/result bundle for the 48/16 sequential divider.
// The master side drives ce/start/operands; the divider (slave) returns status and results.
interface divider_48_16_if #(
    parameter int ASIZE = 32,
    parameter int BSIZE = 16
);
    localparam int PSIZE = ASIZE + BSIZE;

    logic             ce;
    logic             start;
    logic [PSIZE-1:0] a;
    logic [BSIZE-1:0] b;
    logic             busy;
    logic             done;
    logic [ASIZE-1:0] q;
    logic [BSIZE-1:0] r;
    logic             dz;
    logic             ovf;
    logic [1:0]       state_dbg;

    modport master (
        output ce, start, a, b,
        input  busy, done, q, r, dz, ovf, state_dbg
    );

    modport slave (
        input  ce, start, a, b,
        output busy, done, q, r, dz, ovf, state_dbg
    );
endinterface

// File: rtl/divider_48_16.sv
// Radix-2 restoring divider: 48-bit dividend / 16-bit divisor -> 32-bit quotient, 16-bit remainder.
// Define DIV_ROUND_EN to add a ROUND state that rounds the quotient half-up (saturating).
module divider_48_16 #(
    parameter int ASIZE = 32,
    parameter int BSIZE = 16
) (
    input logic           clk,
    input logic           rst,
    divider_48_16_if.slave bus
);
    localparam int PSIZE = ASIZE + BSIZE;
    localparam int CW    = $clog2(ASIZE + 1);

    // Handshake: start is a request taken only in IDLE with ce=1 (no queuing while busy);
    // busy is high from that accept until the done cycle is consumed by a ce=1 edge;
    // done is high for exactly one enabled cycle per accepted request, results held until next accept.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             err_dz;
    logic             err_ovf;

    logic [BSIZE-1:0] pr;
    logic [ASIZE-1:0] sh;
    logic [BSIZE-1:0] b_reg;
    logic [CW-1:0]    cnt;
    logic [ASIZE-1:0] q_reg;
    logic [BSIZE-1:0] r_reg;
    logic             dz_reg;
    logic             ovf_reg;

    logic [BSIZE:0]   t;
    logic             qbit;
    logic [BSIZE-1:0] pr_step;
    logic [ASIZE-1:0] sh_step;
    logic             last_step;

    assign err_dz  = (bus.b == '0);
    assign err_ovf = (bus.a[PSIZE-1:ASIZE] >= bus.b);

    // One restoring step; pr < b_reg always holds, so t - b_reg fits in BSIZE bits.
    assign t         = {pr, sh[ASIZE-1]};
    assign qbit      = (t >= {1'b0, b_reg});
    assign pr_step   = qbit ? BSIZE'(t - {1'b0, b_reg}) : t[BSIZE-1:0];
    assign sh_step   = {sh[ASIZE-2:0], qbit};
    assign last_step = (cnt == CW'(1));

`ifdef DIV_ROUND_EN
    logic round_up;
    assign round_up = ({r_reg, 1'b0} >= {1'b0, b_reg}) && (q_reg != '1);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        if (bus.ce) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        accept = 1'b1;
                        if (err_dz || err_ovf) begin
                            state_next = DONE;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    if (last_step) begin
`ifdef DIV_ROUND_EN
                        state_next = ROUND;
`else
                        state_next = DONE;
`endif
                    end
                end
                ROUND:   state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pr      <= '0;
            sh      <= '0;
            b_reg   <= '0;
            cnt     <= '0;
            q_reg   <= '0;
            r_reg   <= '0;
            dz_reg  <= 1'b0;
            ovf_reg <= 1'b0;
        end else if (bus.ce) begin
            if (accept) begin
                q_reg   <= '0;
                r_reg   <= '0;
                dz_reg  <= 1'b0;
                ovf_reg <= 1'b0;
                if (err_dz) begin
                    dz_reg <= 1'b1;
                    q_reg  <= '1;
                end else if (err_ovf) begin
                    ovf_reg <= 1'b1;
                    q_reg   <= '1;
                end else begin
                    pr    <= bus.a[PSIZE-1:ASIZE];
                    sh    <= bus.a[ASIZE-1:0];
                    b_reg <= bus.b;
                    cnt   <= CW'(ASIZE);
                end
            end else if (state == RUN) begin
                pr  <= pr_step;
                sh  <= sh_step;
                cnt <= cnt - CW'(1);
                if (last_step) begin
                    q_reg <= sh_step;
                    r_reg <= pr_step;
                end
            end
`ifdef DIV_ROUND_EN
            else if (state == ROUND) begin
                if (round_up) begin
                    q_reg <= q_reg + ASIZE'(1);
                end
            end
`endif
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.q         = q_reg;
    assign bus.r         = r_reg;
    assign bus.dz        = dz_reg;
    assign bus.ovf       = ovf_reg;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_divider_48_16.sv
// Self-checking bench for divider_48_16: directed vector table, corner sequences,
// and randomized back-to-back operation against an arithmetic reference model.
module tb_divider_48_16;
    localparam int ASIZE = 32;
    localparam int BSIZE = 16;
`ifdef DIV_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif
    localparam int LAT_OK = ASIZE + 1 + RND;
    localparam int NRAND  = 300;

    typedef struct {
        logic [47:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
        logic        ovf;
        int          lat;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     checks = 0;
    int     failures = 0;
    longint cyc = 0;

    divider_48_16_if bus();

    divider_48_16 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Reference: plain integer division on the full dividend, overflow when the quotient exceeds 32 bits.
    function automatic void model(input logic [47:0] a, input logic [15:0] b,
                                  output logic [31:0] q, output logic [15:0] r,
                                  output logic dz, output logic ovf, output int lat);
        logic [47:0] qq;
        logic [47:0] rr;
        dz  = 1'b0;
        ovf = 1'b0;
        q   = '1;
        r   = '0;
        lat = 1;
        if (b == 16'd0) begin
            dz = 1'b1;
        end else begin
            qq = a / {32'd0, b};
            rr = a % {32'd0, b};
            if (qq > 48'h0000_FFFF_FFFF) begin
                ovf = 1'b1;
            end else begin
                q   = qq[31:0];
                r   = rr[15:0];
                lat = LAT_OK;
                if (RND == 1 && (rr << 1) >= {32'd0, b} && q != 32'hFFFF_FFFF) q = q + 32'd1;
            end
        end
    endfunction

    task automatic run_op(input logic [47:0] a, input logic [15:0] b, output int lat, output logic seen);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 200) begin
            tick();
            lat++;
        end
        seen = bus.done;
    endtask

    vec_t        vecs[9];
    int          lat;
    logic        seen;
    int          pulses;
    int          stray;
    logic [47:0] ra;
    logic [15:0] rb;
    logic [15:0] ahi;
    logic [31:0] eq;
    logic [15:0] er;
    logic        edz;
    logic        eovf;
    int          elat;
    int          exp_gap;
    longint      acc;
    longint      prev_acc;
    logic        pb;
    int          w;
    int          sel;

    initial begin
        vecs[0] = '{48'd1000, 16'd7, 32'(142 + RND), 16'd6, 1'b0, 1'b0, LAT_OK};
        vecs[1] = '{48'hFFFE_FFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF, 16'hFFFE, 1'b0, 1'b0, LAT_OK};
        vecs[2] = '{48'd12345, 16'd0, 32'hFFFF_FFFF, 16'd0, 1'b1, 1'b0, 1};
        vecs[3] = '{48'h0001_0000_0000, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0, 1'b1, 1};
        vecs[4] = '{48'd10, 16'd4, 32'(2 + RND), 16'd2, 1'b0, 1'b0, LAT_OK};
        vecs[5] = '{48'd0, 16'd5, 32'd0, 16'd0, 1'b0, 1'b0, LAT_OK};
        vecs[6] = '{48'h0000_FFFF_FFFF, 16'd1, 32'hFFFF_FFFF, 16'd0, 1'b0, 1'b0, LAT_OK};
        vecs[7] = '{48'd100, 16'd3, 32'd33, 16'd1, 1'b0, 1'b0, LAT_OK};
        vecs[8] = '{48'd101, 16'd3, 32'(33 + RND), 16'd2, 1'b0, 1'b0, LAT_OK};

        bus.ce    = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        rst       = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_q", bus.q, 0);
        check("reset_r", bus.r, 0);
        check("reset_dz", bus.dz, 0);
        check("reset_ovf", bus.ovf, 0);

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat, seen);
            check($sformatf("vec%0d_done", i), seen, 1);
            check($sformatf("vec%0d_q", i), bus.q, vecs[i].q);
            check($sformatf("vec%0d_r", i), bus.r, vecs[i].r);
            check($sformatf("vec%0d_dz", i), bus.dz, vecs[i].dz);
            check($sformatf("vec%0d_ovf", i), bus.ovf, vecs[i].ovf);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            tick();
            check($sformatf("vec%0d_done_drop", i), bus.done, 0);
            check($sformatf("vec%0d_idle", i), bus.busy, 0);
        end

        // Stall mid-RUN with ce low for 5 cycles; start pulses while busy must be ignored.
        bus.a     = 48'd10;
        bus.b     = 16'd4;
        bus.start = 1'b1;
        tick();
        lat    = 1;
        pulses = 0;
        stray  = 0;
        for (int i = 0; i < 9; i++) begin
            bus.start = (i == 3);
            tick();
            lat++;
            if (bus.done) pulses++;
        end
        bus.start = 1'b0;
        bus.ce    = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.start = (i == 2);
            tick();
            lat++;
            if (bus.done) pulses++;
        end
        bus.start = 1'b0;
        bus.ce    = 1'b1;
        while (!bus.done && lat < 200) begin
            tick();
            lat++;
        end
        if (bus.done) pulses++;
        check("stall_lat", lat, 38 + RND);
        check("stall_q", bus.q, 2 + RND);
        check("stall_r", bus.r, 2);
        bus.ce = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_done_hold", bus.done, 1);
        end
        bus.ce = 1'b1;
        tick();
        check("stall_done_consumed", bus.done, 0);
        check("stall_idle", bus.busy, 0);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) pulses++;
            if (bus.busy) stray++;
        end
        check("stall_one_pulse", pulses, 1);
        check("stall_start_ignored", stray, 0);

        // Reset at RUN step 10: everything clears and no done follows.
        bus.a     = 48'd1000;
        bus.b     = 16'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_q", bus.q, 0);
        check("rst_r", bus.r, 0);
        check("rst_dz", bus.dz, 0);
        check("rst_ovf", bus.ovf, 0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) pulses++;
        end
        check("rst_no_done", pulses, 0);
        run_op(48'd1000, 16'd7, lat, seen);
        check("post_rst_done", seen, 1);
        check("post_rst_q", bus.q, 142 + RND);
        check("post_rst_r", bus.r, 6);
        check("post_rst_lat", lat, LAT_OK);
        tick();

        // Back-to-back with start held high and random operands, including error cases.
        bus.start = 1'b1;
        prev_acc  = 0;
        exp_gap   = 0;
        for (int n = 0; n < NRAND; n++) begin
            sel = $urandom_range(0, 15);
            rb  = 16'($urandom);
            if (sel < 2) rb = 16'd0;
            else if (sel < 5) rb = 16'($urandom_range(1, 15));
            if (rb == 16'd0) ahi = 16'($urandom);
            else if (sel == 5 || sel == 6) ahi = 16'($urandom_range(int'(rb), 65535));
            else ahi = 16'($urandom % int'(rb));
            ra = {ahi, 32'($urandom)};
            model(ra, rb, eq, er, edz, eovf, elat);
            bus.a = ra;
            bus.b = rb;
            w = 0;
            do begin
                pb = bus.busy;
                tick();
                w++;
            end while (!(bus.busy && !pb) && w < 100);
            if (!(bus.busy && !pb)) begin
                check("b2b_accept_timeout", 0, 1);
                break;
            end
            acc = cyc;
            if (n > 0) check("b2b_gap", 64'(acc - prev_acc), 64'(exp_gap));
            w = 0;
            while (!bus.done && w < 200) begin
                tick();
                w++;
            end
            check("b2b_done", bus.done, 1);
            check("b2b_lat", 64'(cyc - acc + 1), 64'(elat));
            check("b2b_q", bus.q, eq);
            check("b2b_r", bus.r, er);
            check("b2b_dz", bus.dz, edz);
            check("b2b_ovf", bus.ovf, eovf);
            exp_gap  = elat + 1;
            prev_acc = acc;
        end
        bus.start = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
